// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : MIPS fetch stage: PC register, word-addressed instruction memory,
//            instruction field decode and start/run/halt control FSM.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [31:0]                   branch_offset,
    input  logic                          jump,
    input  logic [25:0]                   jump_target,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   pc,
    output logic [31:0]                   pc_plus4,
    output logic [31:0]                   instr,
    output logic [5:0]                    opcode,
    output logic [4:0]                    rs,
    output logic [4:0]                    rt,
    output logic [4:0]                    rd,
    output logic [5:0]                    funct,
    output logic [15:0]                   imm16,
    output logic                          valid,
    output logic                          halted,
    output logic                          fault
);

    localparam int          c_ADDR_W  = $clog2(IMEM_DEPTH);
    localparam logic [31:0] c_DEPTH32 = 32'(IMEM_DEPTH);
    localparam logic [5:0]  c_OP_HALT = 6'b111111;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        r_halted;
    logic        r_fault;
    logic        w_fault_set;
    logic [31:0] r_mem [IMEM_DEPTH];

    logic        w_in_range;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_pc;
    logic [31:0] w_branch_pc;

    // Word memory, no reset: writes land even while reset is asserted.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            r_mem[imem_waddr] <= imem_wdata;
        end
    end

    assign w_in_range  = ({2'b00, r_pc[31:2]} < c_DEPTH32);
    assign w_valid     = (r_state == ST_RUN) && w_in_range;
    assign w_instr     = w_valid ? r_mem[r_pc[c_ADDR_W+1:2]] : 32'h0000_0000;
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_jump_pc   = {w_pc_plus4[31:28], jump_target, 2'b00};
    assign w_branch_pc = w_pc_plus4 + (branch_offset << 2);

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_fault_set  = 1'b0;
        case (r_state)
            ST_START: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                // PC stays put on entry to HALT so the halting address remains visible.
                if (!w_in_range) begin
                    w_state_next = ST_HALT;
                    w_fault_set  = 1'b1;
                end else if ((w_instr[31:26] == c_OP_HALT) && !stall) begin
                    w_state_next = ST_HALT;
                end else if (stall) begin
                    w_pc_next = r_pc;
                end else if (jump) begin
                    w_pc_next = w_jump_pc;
                end else if (branch_taken) begin
                    w_pc_next = w_branch_pc;
                end else begin
                    w_pc_next = w_pc_plus4;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_START;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_halted <= (w_state_next == ST_HALT);
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign instr    = w_instr;
    assign opcode   = w_instr[31:26];
    assign rs       = w_instr[25:21];
    assign rt       = w_instr[20:16];
    assign rd       = w_instr[15:11];
    assign funct    = w_instr[5:0];
    assign imm16    = w_instr[15:0];
    assign valid    = w_valid;
    assign halted   = r_halted;
    assign fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Directed and randomized self-checking bench for instr_fetch.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;

    localparam int          DEPTH = 16;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, imem_we;
    logic [31:0] branch_offset, imem_wdata;
    logic [25:0] jump_target;
    logic [3:0]  imem_waddr;
    logic [31:0] pc, pc_plus4, instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic        valid, halted, fault;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: 0 = start, 1 = run, 2 = halt
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    int          m_st;
    bit          m_halted, m_fault;

    instr_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm16(imm16),
        .valid(valid), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic bit m_valid();
        return (m_st == 1) && (m_pc / 4 < DEPTH);
    endfunction

    function automatic logic [31:0] m_instr();
        return m_valid() ? m_mem[m_pc[5:2]] : 32'h0;
    endfunction

    task automatic model_edge();
        logic [31:0] cur;
        logic [31:0] p4;
        bit          v;
        cur = m_instr();
        v   = m_valid();
        p4  = m_pc + 32'd4;
        if (reset) begin
            m_st = 0; m_pc = RPC; m_halted = 0; m_fault = 0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (!v) begin
                m_st = 2; m_halted = 1; m_fault = 1;
            end else if (cur[31:26] == 6'h3F && !stall) begin
                m_st = 2; m_halted = 1; m_fault = 0;
            end else if (!stall) begin
                if (jump)              m_pc = {p4[31:28], jump_target, 2'b00};
                else if (branch_taken) m_pc = p4 + branch_offset * 32'd4;
                else                   m_pc = p4;
            end
        end
        if (imem_we) m_mem[imem_waddr] = imem_wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] prog [5];
        prog = '{32'h2001_0005, 32'h2002_0003, 32'h0000_0020, 32'h0000_0000, 32'hFC00_0000};
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 4'(i);
            imem_wdata = (i < 5) ? prog[i] : 32'h0;
            tick();
        end
        imem_we = 1'b0;
        n_vec++; if (pc !== 32'h0)  begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
        n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
    endtask

    task automatic test_startup();
        reset = 1'b0;
        n_vec++; if (valid !== 1'b0 || pc !== 32'h0) begin n_err++; $display("FAIL start_cycle: valid %b pc %h want 0 / 0", valid, pc); end
        tick();
        n_vec++; if (pc !== 32'h0 || valid !== 1'b1) begin n_err++; $display("FAIL fetch0_pc: pc %h valid %b want 0 / 1", pc, valid); end
        n_vec++; if (instr !== 32'h2001_0005) begin n_err++; $display("FAIL fetch0_instr: got %h want 20010005", instr); end
        n_vec++; if (imm16 !== 16'h0005 || opcode !== 6'h08 || rt !== 5'd1) begin n_err++; $display("FAIL fetch0_fields: imm %h op %h rt %h want 0005/08/01", imm16, opcode, rt); end
        tick();
        n_vec++; if (pc !== 32'h4 || instr !== 32'h2002_0003) begin n_err++; $display("FAIL fetch1: pc %h instr %h want 4 / 20020003", pc, instr); end
        n_vec++; if (imm16 !== 16'h0003) begin n_err++; $display("FAIL fetch1_imm: got %h want 0003", imm16); end
        tick();
        n_vec++; if (pc !== 32'h8 || funct !== 6'h20) begin n_err++; $display("FAIL fetch2: pc %h funct %h want 8 / 20", pc, funct); end
    endtask

    task automatic test_branch_back();
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
        tick();
        branch_taken = 1'b0; branch_offset = 32'h0;
        n_vec++; if (pc !== 32'h4 || instr !== 32'h2002_0003) begin n_err++; $display("FAIL branch_back: pc %h instr %h want 4 / 20020003", pc, instr); end
        n_vec++; if (pc_plus4 !== 32'h8) begin n_err++; $display("FAIL branch_pc4: got %h want 8", pc_plus4); end
    endtask

    task automatic test_jump_beats_branch();
        jump = 1'b1; jump_target = 26'h10; branch_taken = 1'b1; branch_offset = 32'h1;
        tick();
        jump = 1'b0; branch_taken = 1'b0;
        n_vec++; if (pc !== 32'h40) begin n_err++; $display("FAIL jump_pc: got %h want 40", pc); end
        n_vec++; if (valid !== 1'b0 || instr !== 32'h0 || halted !== 1'b0) begin n_err++; $display("FAIL oob_cycle: valid %b instr %h halted %b want 0/0/0", valid, instr, halted); end
        tick();
        n_vec++; if (halted !== 1'b1 || fault !== 1'b1 || pc !== 32'h40) begin n_err++; $display("FAIL fault_halt: halted %b fault %b pc %h want 1/1/40", halted, fault, pc); end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick();
        stall = 1'b1; jump = 1'b1; jump_target = 26'h10;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (pc !== 32'h4 || instr !== 32'h2002_0003 || valid !== 1'b1) begin n_err++; $display("FAIL stall_hold: pc %h instr %h valid %b want 4/20020003/1", pc, instr, valid); end
        end
        stall = 1'b0;
        tick();
        jump = 1'b0;
        n_vec++; if (pc !== 32'h40 || valid !== 1'b0) begin n_err++; $display("FAIL stall_release: pc %h valid %b want 40 / 0", pc, valid); end
        tick();
        n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL stall_fault: got %b want 1", fault); end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (5) tick();
        n_vec++; if (pc !== 32'h10 || valid !== 1'b1 || opcode !== 6'h3F) begin n_err++; $display("FAIL halt_fetch: pc %h valid %b op %h want 10/1/3f", pc, valid, opcode); end
        branch_taken = 1'b1; branch_offset = 32'h5;
        tick();
        n_vec++; if (halted !== 1'b1 || valid !== 1'b0 || fault !== 1'b0 || pc !== 32'h10) begin n_err++; $display("FAIL halt_state: halted %b valid %b fault %b pc %h want 1/0/0/10", halted, valid, fault, pc); end
        tick();
        n_vec++; if (pc !== 32'h10 || halted !== 1'b1) begin n_err++; $display("FAIL halt_frozen: pc %h halted %b want 10 / 1", pc, halted); end
        branch_taken = 1'b0;
        do_reset();
        n_vec++; if (pc !== 32'h0 || halted !== 1'b0 || valid !== 1'b0) begin n_err++; $display("FAIL halt_reset: pc %h halted %b valid %b want 0/0/0", pc, halted, valid); end
    endtask

    task automatic test_write_hazard();
        do_reset();
        tick();
        stall = 1'b1; imem_we = 1'b1; imem_waddr = 4'd0; imem_wdata = 32'h1234_5678;
        n_vec++; if (instr !== 32'h2001_0005) begin n_err++; $display("FAIL wr_old_word: got %h want 20010005", instr); end
        tick();
        imem_we = 1'b0; stall = 1'b0;
        n_vec++; if (instr !== 32'h1234_5678 || pc !== 32'h0) begin n_err++; $display("FAIL wr_new_word: instr %h pc %h want 12345678 / 0", instr, pc); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] ei;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom % 40) == 0;
            stall         = ($urandom % 4) == 0;
            jump          = ($urandom % 8) == 0;
            jump_target   = 26'($urandom % 20);
            branch_taken  = ($urandom % 4) == 0;
            branch_offset = 32'(int'($urandom_range(12, 0)) - 6);
            imem_we       = ($urandom % 3) == 0;
            imem_waddr    = 4'($urandom % DEPTH);
            r             = $urandom;
            imem_wdata    = (($urandom % 10) == 0) ? {6'h3F, r[25:0]} : r;
            tick();
            ei = m_instr();
            n_vec++; if (pc !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, pc, m_pc); end
            n_vec++; if (pc_plus4 !== m_pc + 32'd4) begin n_err++; $display("FAIL rnd_pc4[%0d]: got %h want %h", n, pc_plus4, m_pc + 32'd4); end
            n_vec++; if (valid !== m_valid()) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, valid, m_valid()); end
            n_vec++; if (instr !== ei) begin n_err++; $display("FAIL rnd_instr[%0d]: got %h want %h", n, instr, ei); end
            n_vec++; if ({opcode, rs, rt, rd, funct, imm16} !== {ei[31:26], ei[25:21], ei[20:16], ei[15:11], ei[5:0], ei[15:0]}) begin
                n_err++; $display("FAIL rnd_fields[%0d]: op %h rs %h rt %h rd %h fn %h imm %h for instr %h", n, opcode, rs, rt, rd, funct, imm16, ei);
            end
            n_vec++; if (halted !== m_halted || fault !== m_fault) begin n_err++; $display("FAIL rnd_status[%0d]: halted %b fault %b want %b %b", n, halted, fault, m_halted, m_fault); end
        end
        reset = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0; imem_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_we = 1'b0;
        branch_offset = 32'h0; jump_target = 26'h0; imem_waddr = 4'h0; imem_wdata = 32'h0;
        m_st = 0; m_pc = RPC; m_halted = 0; m_fault = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        @(negedge clk);
        test_reset();
        test_startup();
        test_branch_back();
        test_jump_beats_branch();
        test_stall();
        test_halt();
        test_write_hazard();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
